// File: rtl/sweep_lock_ctrl_pkg.sv
// Shared types and widths for the cutting-drive sweep/lock controller.
package cutting_pkg;

  localparam int INC_W   = 15;
  localparam int THETA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    STEP,
    END,
    LOCKED,
    FAULT
  } state_e;

  typedef struct packed {
    logic [INC_W-1:0]   f_start;
    logic [INC_W-1:0]   f_stop;
    logic [THETA_W-1:0] f_step;
  } sweep_cfg_t;

  // A zero step never advances and an inverted range has no steps.
  function automatic logic cfg_bad(input sweep_cfg_t c);
    return (c.f_step == '0) || (c.f_start > c.f_stop);
  endfunction

endpackage

// File: rtl/sweep_lock_ctrl_if.sv
// Command/config/phase-detector inputs and ICO/status outputs of the sweep controller.
interface sweep_lock_ctrl_if;
  import cutting_pkg::*;

  logic               start;
  logic               abort;
  logic [INC_W-1:0]   f_start;
  logic [INC_W-1:0]   f_stop;
  logic [THETA_W-1:0] f_step;
  logic               theta_valid;
  logic [THETA_W-1:0] abs_theta;

  logic [INC_W-1:0]   increment;
  logic               sweep_active;
  logic               stop;
  logic [INC_W-1:0]   lock_point;
  logic [THETA_W-1:0] best_theta;
  logic               done;
  logic               err;

  modport master (
    output start, abort, f_start, f_stop, f_step, theta_valid, abs_theta,
    input  increment, sweep_active, stop, lock_point, best_theta, done, err
  );

  modport slave (
    input  start, abort, f_start, f_stop, f_step, theta_valid, abs_theta,
    output increment, sweep_active, stop, lock_point, best_theta, done, err
  );

endinterface

// File: rtl/sweep_lock_ctrl_theta_averager.sv
// Sums 2^AVG_LOG2 theta samples; avg is presented combinationally with the last sample.
module theta_averager
  import cutting_pkg::*;
#(
  parameter int AVG_LOG2 = 2
) (
  input  logic               clk40MHz,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_valid,
  input  logic [THETA_W-1:0] i_theta,
  output logic [THETA_W-1:0] o_avg,
  output logic               o_avg_valid
);
  localparam int ACC_W = THETA_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_sum;
  logic             w_last;

  assign w_sum       = r_acc + ACC_W'(i_theta);
  assign w_last      = (r_cnt == CNT_W'((1 << AVG_LOG2) - 1));
  assign o_avg_valid = i_valid && w_last;
  // Truncating divide: drop the AVG_LOG2 low bits of the full sum.
  assign o_avg       = w_sum[ACC_W-1:AVG_LOG2];

  // Accumulate samples; restart after each complete group or on clear.
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (i_valid) begin
      if (w_last) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_sum;
      end
    end
  end

endmodule

// File: rtl/sweep_lock_ctrl.sv
// Coarse ICO frequency sweep: settle/measure each step, keep min-theta step, seed tracking.
module sweep_lock_ctrl
  import cutting_pkg::*;
#(
  parameter int                 AVG_LOG2   = 2,
  parameter int                 SETTLE_CYC = 16,
  parameter int                 TIMEOUT    = 40000,
  parameter logic [THETA_W-1:0] THETA_MAX  = 8'd100
) (
  input logic              clk40MHz,
  input logic              rst_n,
  sweep_lock_ctrl_if.slave if_bus
);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_e             r_state, w_next;
  sweep_cfg_t         w_cfg_in;
  logic [INC_W-1:0]   r_f_stop;
  logic [THETA_W-1:0] r_f_step;
  logic [INC_W-1:0]   r_inc;
  logic [INC_W-1:0]   r_lock;
  logic [THETA_W-1:0] r_best;
  logic               r_done;
  logic [SET_W-1:0]   r_settle_cnt;
  logic [TO_W-1:0]    r_to_cnt;

  logic [INC_W:0]     w_next_wide;
  logic               w_step_over;
  logic               w_timed;
  logic               w_timeout;
  logic               w_settle_last;
  logic               w_avg_clr;
  logic               w_avg_in;
  logic               w_avg_valid;
  logic [THETA_W-1:0] w_avg;
  logic               w_sweep_active;
  logic               w_stop;
  logic               w_err;

  assign w_cfg_in = '{f_start: if_bus.f_start, f_stop: if_bus.f_stop, f_step: if_bus.f_step};

  // One bit wider than INC_W so a step past 0x7FFF reads as "beyond f_stop", not a wrap.
  assign w_next_wide = {1'b0, r_inc} + {{(INC_W + 1 - THETA_W){1'b0}}, r_f_step};
  assign w_step_over = w_next_wide > {1'b0, r_f_stop};

  assign w_timed       = (r_state == SETTLE) || (r_state == MEASURE);
  assign w_timeout     = w_timed && !if_bus.theta_valid && (r_to_cnt == TO_W'(TIMEOUT - 1));
  assign w_settle_last = if_bus.theta_valid && (r_settle_cnt == SET_W'(SETTLE_CYC - 1));

  // Averager only sees samples consumed in MEASURE; any exit drops a partial sum.
  assign w_avg_clr = (r_state != MEASURE) || if_bus.start || if_bus.abort;
  assign w_avg_in  = if_bus.theta_valid && !w_avg_clr;

  theta_averager #(.AVG_LOG2(AVG_LOG2)) u_avg (
    .clk40MHz    (clk40MHz),
    .rst_n       (rst_n),
    .i_clr       (w_avg_clr),
    .i_valid     (w_avg_in),
    .i_theta     (if_bus.abs_theta),
    .o_avg       (w_avg),
    .o_avg_valid (w_avg_valid)
  );

  // State register.
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state: abort beats start, start restarts from anywhere.
  always_comb begin
    w_next = r_state;
    if (if_bus.abort) begin
      w_next = IDLE;
    end else if (if_bus.start) begin
      w_next = cfg_bad(w_cfg_in) ? FAULT : SETTLE;
    end else begin
      case (r_state)
        SETTLE:  if (w_timeout) w_next = FAULT;
                 else if (w_settle_last) w_next = MEASURE;
        MEASURE: if (w_timeout) w_next = FAULT;
                 else if (w_avg_valid) w_next = STEP;
        STEP:    w_next = w_step_over ? END : SETTLE;
        END:     w_next = (r_best > THETA_MAX) ? FAULT : LOCKED;
        default: w_next = r_state;
      endcase
    end
  end

  // Gate/mux outputs decode straight from state so reset gates off asynchronously.
  always_comb begin
    w_sweep_active = 1'b0;
    w_stop         = 1'b1;
    w_err          = 1'b0;
    case (r_state)
      SETTLE, MEASURE, STEP, END: begin
        w_sweep_active = 1'b1;
        w_stop         = 1'b0;
      end
      LOCKED:  w_stop = 1'b0;
      FAULT:   w_err  = 1'b1;
      default: ;
    endcase
  end

  // Discard SETTLE_CYC drive cycles after each frequency change.
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n)                                                         r_settle_cnt <= '0;
    else if (r_state != SETTLE || if_bus.start || if_bus.abort)         r_settle_cnt <= '0;
    else if (if_bus.theta_valid)                                        r_settle_cnt <= r_settle_cnt + 1'b1;
  end

  // Cycles since the last theta_valid while waiting on the phase detector.
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n)                                                         r_to_cnt <= '0;
    else if (!w_timed || if_bus.theta_valid || if_bus.start || if_bus.abort) r_to_cnt <= '0;
    else if (!w_timeout)                                                r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Sweep datapath: config latch, increment, best tracking, done pulse.
  always_ff @(posedge clk40MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_f_stop <= '0;
      r_f_step <= '0;
      r_inc    <= '0;
      r_lock   <= '0;
      r_best   <= '1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (if_bus.abort) begin
        r_done <= 1'b0;
      end else if (if_bus.start) begin
        if (!cfg_bad(w_cfg_in)) begin
          r_f_stop <= w_cfg_in.f_stop;
          r_f_step <= w_cfg_in.f_step;
          r_inc    <= w_cfg_in.f_start;
          r_best   <= '1;
        end
      end else begin
        case (r_state)
          // Strict less-than: on a tie the earlier (lower) frequency stays.
          MEASURE: if (w_avg_valid && (w_avg < r_best)) begin
                     r_best <= w_avg;
                     r_lock <= r_inc;
                   end
          STEP:    if (!w_step_over) r_inc <= w_next_wide[INC_W-1:0];
          END:     if (r_best <= THETA_MAX) begin
                     r_inc  <= r_lock;
                     r_done <= 1'b1;
                   end
          default: ;
        endcase
      end
    end
  end

  assign if_bus.increment    = r_inc;
  assign if_bus.sweep_active = w_sweep_active;
  assign if_bus.stop         = w_stop;
  assign if_bus.lock_point   = r_lock;
  assign if_bus.best_theta   = r_best;
  assign if_bus.done         = r_done;
  assign if_bus.err          = w_err;

endmodule

// File: tb/tb_sweep_lock_ctrl.sv
// Bench for sweep_lock_ctrl: sweep/lock model compared every cycle plus directed literal checks.
module tb_sweep_lock_ctrl;
  import cutting_pkg::*;

  localparam int TMO = 400;

  logic clk40MHz = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk40MHz = ~clk40MHz;

  sweep_lock_ctrl_if ifc ();

  sweep_lock_ctrl #(
    .AVG_LOG2   (2),
    .SETTLE_CYC (16),
    .TIMEOUT    (TMO),
    .THETA_MAX  (8'd100)
  ) dut (
    .clk40MHz (clk40MHz),
    .rst_n    (rst_n),
    .if_bus   (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Plant: phase error seen at a given increment; every 4th sample (idx%4==1) carries +3 jitter.
  function automatic logic [7:0] theta_of(input int pl, input int inc, input int idx);
    int b;
    case (pl)
      0:       b = 10 + ((inc > 12500) ? (inc - 12500) : (12500 - inc)) / 2;
      1:       b = 30;
      2:       b = 120;
      default: b = 100;
    endcase
    if (idx % 4 == 1) b += 3;
    if (b > 255) b = 255;
    return 8'(b);
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 sweeping, 2 locked, 3 fault. Within a sweep step: 20 pulses
  // (16 discarded, 4 averaged), then one step-decision cycle, then one end cycle if over.
  int m_mode = 0, m_inc = 0, m_lock = 0, m_best = 255, m_done = 0;
  int c_stop = 0, c_step = 0;
  int m_pulses = 0, m_sum = 0, m_post = 0, m_quiet = 0;

  initial forever begin
    @(posedge clk40MHz or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_inc = 0; m_lock = 0; m_best = 255; m_done = 0;
    end else begin
      m_done = 0;
      if (ifc.abort) begin
        m_mode = 0;
      end else if (ifc.start) begin
        if (ifc.f_step == 0 || ifc.f_start > ifc.f_stop) m_mode = 3;
        else begin
          m_mode = 1; c_stop = int'(ifc.f_stop); c_step = int'(ifc.f_step);
          m_inc = int'(ifc.f_start); m_best = 255;
          m_pulses = 0; m_sum = 0; m_post = 0; m_quiet = 0;
        end
      end else if (m_mode == 1) begin
        if (m_post == 1) begin
          if (m_inc + c_step > c_stop) m_post = 2;
          else begin
            m_inc = m_inc + c_step; m_post = 0; m_pulses = 0; m_sum = 0; m_quiet = 0;
          end
        end else if (m_post == 2) begin
          if (m_best > 100) m_mode = 3;
          else begin m_mode = 2; m_inc = m_lock; m_done = 1; end
        end else if (ifc.theta_valid) begin
          m_quiet = 0;
          if (m_pulses >= 16) m_sum += int'(ifc.abs_theta);
          m_pulses++;
          if (m_pulses == 20) begin
            if (m_sum / 4 < m_best) begin m_best = m_sum / 4; m_lock = m_inc; end
            m_post = 1;
          end
        end else begin
          m_quiet++;
          if (m_quiet == TMO) m_mode = 3;
        end
      end
    end
  end

  // Every-cycle compare of all outputs against the model.
  int cyc = 0;
  initial forever begin
    logic [41:0] act, exp;
    @(negedge clk40MHz);
    cyc++;
    act = {ifc.increment, ifc.sweep_active, ifc.stop, ifc.lock_point, ifc.best_theta, ifc.done, ifc.err};
    exp = {15'(m_inc), (m_mode == 1), (m_mode == 0 || m_mode == 3), 15'(m_lock), 8'(m_best),
           (m_done != 0), (m_mode == 3)};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cycle_cmp @%0d: got inc=%0d sw=%0b stop=%0b lock=%0d best=%0d done=%0b err=%0b, want inc=%0d sw=%0b stop=%0b lock=%0d best=%0d done=%0b err=%0b",
               cyc, act[41:27], act[26], act[25], act[24:10], act[9:2], act[1], act[0],
               exp[41:27], exp[26], exp[25], exp[24:10], exp[9:2], exp[1], exp[0]);
    end
  end

  // ---------------- stimulus helpers and monitors ----------------
  bit pulse_en = 0;
  int plant = 0, pcnt = 0, pidx = 0;

  // Phase detector: one theta_valid pulse every 4 clocks while enabled.
  initial forever begin
    @(negedge clk40MHz);
    ifc.theta_valid = 1'b0;
    if (pulse_en) begin
      pcnt++;
      if (pcnt % 4 == 0) begin
        ifc.theta_valid = 1'b1;
        ifc.abs_theta   = theta_of(plant, int'(ifc.increment), pidx);
        pidx++;
      end
    end
  end

  int done_cnt = 0;
  int incq[$];
  initial forever begin
    @(negedge clk40MHz);
    if (ifc.done) done_cnt++;
    if (ifc.sweep_active && (incq.size() == 0 || int'(ifc.increment) != incq[$]))
      incq.push_back(int'(ifc.increment));
  end

  int edge_cnt = 0, last_v_edge = 0, fault_edge = 0;
  bit prev_err = 0;
  initial forever begin
    @(posedge clk40MHz);
    edge_cnt++;
    if (ifc.theta_valid) last_v_edge = edge_cnt;
  end
  initial forever begin
    @(negedge clk40MHz);
    if (ifc.err && !prev_err) fault_edge = edge_cnt;
    prev_err = ifc.err;
  end

  task automatic do_start(input int fs, input int fe, input int st);
    @(negedge clk40MHz);
    pcnt = 0; pidx = 0; done_cnt = 0; incq.delete();
    ifc.f_start = 15'(fs); ifc.f_stop = 15'(fe); ifc.f_step = 8'(st);
    ifc.start = 1'b1;
    @(negedge clk40MHz);
    ifc.start = 1'b0;
  endtask

  // Wait for LOCKED (no sweep, gates on) or FAULT, bounded.
  task automatic wait_settled(input int maxc, input string nm);
    int n = 0;
    while (n < maxc && !((!ifc.sweep_active && !ifc.stop) || ifc.err)) begin
      @(negedge clk40MHz);
      n++;
    end
    checks++;
    if (n >= maxc) begin
      errors++;
      $display("FAIL %s: no lock/fault within %0d cycles", nm, maxc);
    end
    repeat (2) @(negedge clk40MHz);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ifc.start = 0; ifc.abort = 0; ifc.f_start = 0; ifc.f_stop = 0; ifc.f_step = 0;
    ifc.theta_valid = 0; ifc.abs_theta = 0;
    repeat (3) @(negedge clk40MHz);
    chk("rst_increment", ifc.increment, 0);
    chk("rst_stop", ifc.stop, 1);
    chk("rst_sweep_active", ifc.sweep_active, 0);
    chk("rst_lock_point", ifc.lock_point, 0);
    chk("rst_best_theta", ifc.best_theta, 8'hFF);
    chk("rst_done_err", {ifc.done, ifc.err}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk40MHz);

    // 1: V-shaped plant, minimum 10 at 12500; cfg change after start is ignored.
    plant = 0;
    do_start(12460, 12560, 20);
    chk("t1_first_inc_latency", ifc.increment, 12460);
    chk("t1_sweep_active", ifc.sweep_active, 1);
    ifc.f_stop = 15'd12460; ifc.f_step = 8'd1;
    pulse_en = 1;
    wait_settled(1500, "t1_wait");
    pulse_en = 0;
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_lock_point", ifc.lock_point, 12500);
    chk("t1_best_theta", ifc.best_theta, 10);
    chk("t1_seed_increment", ifc.increment, 12500);
    chk("t1_sweep_active_off", ifc.sweep_active, 0);
    chk("t1_step_count", incq.size(), 6);
    if (incq.size() == 6)
      for (int i = 0; i < 6; i++) chk("t1_step_inc", incq[i], 12460 + 20 * i);

    // 2: flat plant, ties keep the lowest frequency.
    plant = 1;
    do_start(12460, 12560, 20);
    pulse_en = 1;
    wait_settled(1500, "t2_wait");
    pulse_en = 0;
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_lock_point", ifc.lock_point, 12460);
    chk("t2_best_theta", ifc.best_theta, 30);

    // 3: bad configs fault on the next clock, increment untouched.
    do_start(12460, 12560, 0);
    chk("t3_step0_err", ifc.err, 1);
    chk("t3_step0_stop", ifc.stop, 1);
    chk("t3_step0_inc", ifc.increment, 12460);
    @(negedge clk40MHz); ifc.abort = 1'b1;
    @(negedge clk40MHz); ifc.abort = 1'b0;
    chk("t3_abort_idle_err", ifc.err, 0);
    do_start(12600, 12560, 20);
    chk("t3_range_err", ifc.err, 1);
    chk("t3_range_inc", ifc.increment, 12460);

    // 4: pulses stop during step 3 -> fault exactly TMO clocks after the last pulse.
    plant = 0;
    do_start(12460, 12560, 20);
    pulse_en = 1;
    for (int n = 0; n < 600 && ifc.increment != 15'd12500; n++) @(negedge clk40MHz);
    chk("t4_reached_step3", ifc.increment, 12500);
    repeat (30) @(negedge clk40MHz);
    pulse_en = 0;
    wait_settled(TMO + 50, "t4_wait_fault");
    chk("t4_err", ifc.err, 1);
    chk("t4_timeout_clks", fault_edge - last_v_edge, TMO);
    plant = 1;
    do_start(12460, 12560, 20);
    pulse_en = 1;
    wait_settled(1500, "t4_recover_wait");
    pulse_en = 0;
    chk("t4_recover_done", done_cnt, 1);
    chk("t4_recover_err", ifc.err, 0);

    // 5: no resonance (theta 120 everywhere) -> fault after END, no done.
    plant = 2;
    do_start(12460, 12560, 20);
    pulse_en = 1;
    wait_settled(1500, "t5_wait");
    pulse_en = 0;
    chk("t5_err", ifc.err, 1);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_best_theta", ifc.best_theta, 120);

    // 6a: abort mid-MEASURE.
    plant = 1;
    do_start(12460, 12560, 20);
    pulse_en = 1;
    repeat (72) @(negedge clk40MHz);
    ifc.abort = 1'b1;
    @(negedge clk40MHz);
    ifc.abort = 1'b0; pulse_en = 0;
    chk("t6_abort_stop", ifc.stop, 1);
    chk("t6_abort_sweep", ifc.sweep_active, 0);
    // 6b: reset mid-SETTLE gates off immediately.
    do_start(12460, 12560, 20);
    pulse_en = 1;
    repeat (20) @(negedge clk40MHz);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_stop_async", ifc.stop, 1);
    chk("t6_rst_inc", ifc.increment, 0);
    chk("t6_rst_best", ifc.best_theta, 8'hFF);
    pulse_en = 0;
    @(negedge clk40MHz);
    rst_n = 1'b1;
    // 6c: start and abort together -> abort wins.
    do_start(12460, 12560, 20);
    repeat (10) @(negedge clk40MHz);
    ifc.start = 1'b1; ifc.abort = 1'b1;
    @(negedge clk40MHz);
    ifc.start = 1'b0; ifc.abort = 1'b0;
    chk("t6_both_sweep", ifc.sweep_active, 0);
    chk("t6_both_stop", ifc.stop, 1);
    chk("t6_both_err", ifc.err, 0);

    // 7: top of range (no 15-bit wrap on the step) with best exactly THETA_MAX.
    plant = 3;
    do_start(32760, 32767, 20);
    pulse_en = 1;
    wait_settled(500, "t7_wait");
    pulse_en = 0;
    chk("t7_done", done_cnt, 1);
    chk("t7_lock_point", ifc.lock_point, 32760);
    chk("t7_best_theta", ifc.best_theta, 100);
    chk("t7_steps", incq.size(), 1);

    repeat (3) @(negedge clk40MHz);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
